// File: rtl/alu32_seq.sv
// alu32_seq: registered, handshaked 32-bit ALU stage.
//
// Accepts one operation (in_valid & in_ready), computes it and holds the
// result until the downstream stage takes it (out_valid & out_ready).  Only
// one op is in flight at a time.  SLL is executed iteratively, one bit per
// cycle; every other op completes in a single cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream presents a, b, op
//   in_ready   stage is idle and can accept (combinational from state)
//   a, b       operands; b[4:0] is the SLL shift amount
//   op         000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB,
//              110 SLT, 111 SLL
//   out_valid  result/zero (/ovf) are valid and held
//   out_ready  downstream accepts the result
//   result     registered result
//   zero       registered (result == 0)
//   ovf        registered signed-overflow flag for ADD/SUB
//
// Optional feature: define ALU32_SEQ_OVF_EN to add the ovf port and its
// logic.  Without it the port and logic are absent.

module alu32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU32_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Shared adder: subtraction reuses it as x + ~y + 1.
  function automatic logic [WIDTH-1:0] add_f(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             cin);
    return x + y + {{(WIDTH-1){1'b0}}, cin};
  endfunction

  // Single-cycle ALU result for every op except SLL (handled by the FSM).
  function automatic logic [WIDTH-1:0] alu_result_f(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y,
                                                    input logic [2:0]       sel);
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             sub_ovf;
    logic [WIDTH-1:0] res;
    sum     = add_f(x, y, 1'b0);
    diff    = add_f(x, ~y, 1'b1);
    sub_ovf = (x[WIDTH-1] != y[WIDTH-1]) & (diff[WIDTH-1] != x[WIDTH-1]);
    case (sel)
      OP_AND:  res = x & y;
      OP_OR:   res = x | y;
      OP_XOR:  res = x ^ y;
      OP_NOR:  res = ~(x | y);
      OP_ADD:  res = sum;
      OP_SUB:  res = diff;
      // Signed less-than: sign of the difference corrected by overflow.
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      OP_SLL:  res = x;
      default: res = {WIDTH{1'b0}};
    endcase
    return res;
  endfunction

`ifdef ALU32_SEQ_OVF_EN
  // Signed overflow of ADD/SUB; zero for all other ops.
  function automatic logic alu_ovf_f(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic [2:0]       sel);
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             flag;
    sum  = add_f(x, y, 1'b0);
    diff = add_f(x, ~y, 1'b1);
    case (sel)
      OP_ADD:  flag = (x[WIDTH-1] == y[WIDTH-1]) & (sum[WIDTH-1] != x[WIDTH-1]);
      OP_SUB:  flag = (x[WIDTH-1] != y[WIDTH-1]) & (diff[WIDTH-1] != x[WIDTH-1]);
      default: flag = 1'b0;
    endcase
    return flag;
  endfunction

  logic ovf_r;
  logic next_ovf_s;
`endif

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] next_work_s;
  logic [4:0]       cnt_r;
  logic [4:0]       next_cnt_s;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] next_result_s;
  logic             zero_r;
  logic             next_zero_s;
  logic             out_valid_r;
  logic             next_valid_s;
  logic [WIDTH-1:0] work_shl_s;

  assign work_shl_s = {work_r[WIDTH-2:0], 1'b0};

  // Next-state and next-register computation for the IDLE/SHIFT/DONE FSM.
  always_comb begin
    next_state_s  = state_r;
    next_work_s   = work_r;
    next_cnt_s    = cnt_r;
    next_result_s = result_r;
    next_valid_s  = out_valid_r;
`ifdef ALU32_SEQ_OVF_EN
    next_ovf_s    = ovf_r;
`endif
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (op == OP_SLL) begin
            if (b[4:0] == 5'd0) begin
              next_result_s = a;
              next_valid_s  = 1'b1;
              next_state_s  = DONE;
`ifdef ALU32_SEQ_OVF_EN
              next_ovf_s    = 1'b0;
`endif
            end else begin
              next_work_s  = a;
              next_cnt_s   = b[4:0];
              next_state_s = SHIFT;
            end
          end else begin
            next_result_s = alu_result_f(a, b, op);
            next_valid_s  = 1'b1;
            next_state_s  = DONE;
`ifdef ALU32_SEQ_OVF_EN
            next_ovf_s    = alu_ovf_f(a, b, op);
`endif
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        next_work_s = work_shl_s;
        next_cnt_s  = cnt_r - 5'd1;
        // Counter reaches zero on this step: the shifted value is final.
        if (cnt_r == 5'd1) begin
          next_result_s = work_shl_s;
          next_valid_s  = 1'b1;
          next_state_s  = DONE;
`ifdef ALU32_SEQ_OVF_EN
          next_ovf_s    = 1'b0;
`endif
        end else begin
          next_state_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_valid_s = 1'b0;
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_valid_s = 1'b0;
        next_state_s = IDLE;
      end
    endcase
    next_zero_s = (next_result_s == {WIDTH{1'b0}});
  end

  // State and datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      work_r      <= {WIDTH{1'b0}};
      cnt_r       <= 5'd0;
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      work_r      <= next_work_s;
      cnt_r       <= next_cnt_s;
      result_r    <= next_result_s;
      zero_r      <= next_zero_s;
      out_valid_r <= next_valid_s;
    end
  end

`ifdef ALU32_SEQ_OVF_EN
  // Overflow flag register, updated together with result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= next_ovf_s;
    end
  end

  assign ovf = ovf_r;
`endif

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_alu32_seq.sv
// tb_alu32_seq: self-checking bench for alu32_seq.
// Directed scenarios plus randomized ops checked against a behavioural model
// built from plain arithmetic (signed compare, native shift, 64-bit sums).

module tb_alu32_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
`ifdef ALU32_SEQ_OVF_EN
  logic        ovf;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  alu32_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
`ifdef ALU32_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from the arithmetic meaning of each op.
  function automatic logic [31:0] model_result(input logic [31:0] x, input logic [31:0] y,
                                               input logic [2:0] o);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x | y);
      3'd4: return x + y;
      3'd5: return x - y;
      3'd6: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return x << y[4:0];
    endcase
  endfunction

  // Reference overflow: does the true signed sum/difference fit in 32 bits?
  function automatic logic model_ovf(input logic [31:0] x, input logic [31:0] y,
                                     input logic [2:0] o);
    longint sx;
    longint sy;
    longint r;
    sx = $signed(x);
    sy = $signed(y);
    if (o == 3'd4) r = sx + sy;
    else if (o == 3'd5) r = sx - sy;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic int model_latency(input logic [31:0] y, input logic [2:0] o);
    if (o == 3'd7 && y[4:0] != 5'd0) return int'(y[4:0]) + 1;
    return 1;
  endfunction

  // Present one op, accept it, scramble inputs, and wait (bounded) for out_valid.
  // Returns at #1 after the edge where out_valid was first seen.
  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input logic [2:0] xop,
                       output int lat);
    a = xa; b = xb; op = xop; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Pulse out_ready for one cycle.
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0; op = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (result !== 32'd0) $display("FAIL reset_result got %h want 0", result); else pass_cnt++;
    total_cnt++; if (zero !== 1'b1) $display("FAIL reset_zero got %0b want 1", zero); else pass_cnt++;
`ifdef ALU32_SEQ_OVF_EN
    total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %0b want 0", ovf); else pass_cnt++;
`endif
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_xor();
    int lat;
    do_op(32'hFFFF0000, 32'h0F0F0F0F, 3'b010, lat);
    total_cnt++; if (lat !== 1) $display("FAIL xor_latency got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (result !== 32'hF0F00F0F) $display("FAIL xor_result got %h want f0f00f0f", result); else pass_cnt++;
    total_cnt++; if (zero !== 1'b0) $display("FAIL xor_zero got %0b want 0", zero); else pass_cnt++;
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(32'h7FFFFFFF, 32'h00000001, 3'b100, lat);
    total_cnt++; if (lat !== 1) $display("FAIL bp_latency got %0d want 1", lat); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (result !== 32'h80000000) $display("FAIL bp_result cyc %0d got %h want 80000000", i, result); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL bp_handshake cyc %0d got in_ready=%0b out_valid=%0b want 0/1", i, in_ready, out_valid); else pass_cnt++;
`ifdef ALU32_SEQ_OVF_EN
      total_cnt++; if (ovf !== 1'b1) $display("FAIL bp_ovf cyc %0d got %0b want 1", i, ovf); else pass_cnt++;
`endif
      @(posedge clk); #1;
    end
    drain();
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_drain got out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); else pass_cnt++;
  endtask

  task automatic test_sll();
    int lat;
    do_op(32'h00000001, 32'd31, 3'b111, lat);
    total_cnt++; if (lat !== 32) $display("FAIL sll31_latency got %0d want 32", lat); else pass_cnt++;
    total_cnt++; if (result !== 32'h80000000) $display("FAIL sll31_result got %h want 80000000", result); else pass_cnt++;
    drain();
    do_op(32'h00000001, 32'd0, 3'b111, lat);
    total_cnt++; if (lat !== 1) $display("FAIL sll0_latency got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (result !== 32'h00000001) $display("FAIL sll0_result got %h want 1", result); else pass_cnt++;
    drain();
  endtask

  task automatic test_signed();
    int lat;
    do_op(32'd5, 32'd5, 3'b101, lat);
    total_cnt++; if (result !== 32'd0 || zero !== 1'b1) $display("FAIL sub_eq got result=%h zero=%0b want 0/1", result, zero); else pass_cnt++;
    drain();
    do_op(32'hFFFFFFFF, 32'd1, 3'b110, lat);
    total_cnt++; if (result !== 32'd1) $display("FAIL slt_neg got %h want 1", result); else pass_cnt++;
    drain();
    do_op(32'd1, 32'hFFFFFFFF, 3'b110, lat);
    total_cnt++; if (result !== 32'd0 || zero !== 1'b1) $display("FAIL slt_pos got result=%h zero=%0b want 0/1", result, zero); else pass_cnt++;
    drain();
  endtask

  task automatic test_ignored();
    int lat;
    logic [31:0] xa;
    logic [31:0] exp;
    xa = $urandom;
    exp = xa << 10;
    a = xa; b = 32'd10; op = 3'b111; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    // Keep toggling in_valid with fresh operands while the shift runs.
    while (!out_valid && lat < 100) begin
      in_valid = 1'($urandom); a = $urandom; b = $urandom; op = 3'($urandom);
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL ign_shift_ready got %0b want 0", in_ready); else pass_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    total_cnt++; if (lat !== 11) $display("FAIL ign_latency got %0d want 11", lat); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom); a = $urandom; b = $urandom; op = 3'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total_cnt++; if (result !== exp || out_valid !== 1'b1) $display("FAIL ign_result got %h valid=%0b want %h/1", result, out_valid, exp); else pass_cnt++;
    drain();
    repeat (3) begin
      @(posedge clk); #1;
      total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL ign_extra_accept got out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    a = 32'h00000003; b = 32'd20; op = 3'b111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL midrst_handshake got out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); else pass_cnt++;
    total_cnt++; if (result !== 32'd0 || zero !== 1'b1) $display("FAIL midrst_result got %h zero=%0b want 0/1", result, zero); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_op(32'h12345678, 32'h11111111, 3'b100, lat);
    total_cnt++; if (lat !== 1 || result !== 32'h23456789) $display("FAIL midrst_next got lat=%0d result=%h want 1/23456789", lat, result); else pass_cnt++;
    drain();
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) break;
    end
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_stale got out_valid=%0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] xa;
    logic [31:0] xb;
    logic [2:0]  xop;
    logic [31:0] exp;
    for (int i = 0; i < 40; i++) begin
      xa = $urandom; xb = $urandom; xop = 3'($urandom);
      if (i % 8 == 0) xb = xa;
      exp = model_result(xa, xb, xop);
      do_op(xa, xb, xop, lat);
      total_cnt++; if (lat !== model_latency(xb, xop)) $display("FAIL rnd_latency op=%0d got %0d want %0d", xop, lat, model_latency(xb, xop)); else pass_cnt++;
      total_cnt++; if (result !== exp || zero !== (exp == 32'd0)) $display("FAIL rnd_result op=%0d a=%h b=%h got %h z=%0b want %h", xop, xa, xb, result, zero, exp); else pass_cnt++;
`ifdef ALU32_SEQ_OVF_EN
      total_cnt++; if (ovf !== model_ovf(xa, xb, xop)) $display("FAIL rnd_ovf op=%0d a=%h b=%h got %0b want %0b", xop, xa, xb, ovf, model_ovf(xa, xb, xop)); else pass_cnt++;
`endif
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      total_cnt++; if (result !== exp) $display("FAIL rnd_hold op=%0d got %h want %h", xop, result, exp); else pass_cnt++;
      drain();
      total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rnd_drain got out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_xor();
    test_backpressure();
    test_sll();
    test_signed();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
